// File: rtl/mips_pkg.sv
// Shared MIPS definitions: data width, wait-counter width and the data-memory responder states.
// The dmem_responder wait-state logic is enabled with the DMEM_WAIT_EN macro.
package mips_pkg;

  localparam int DATA_W     = 32'd32;
  localparam int WAIT_CNT_W = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage with a synchronous write port and a registered read port.
module dmem_array #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int DEPTH  = 32'd256,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Store port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wrData;
    end
  end

  // Load port; the output holds between reads
  always_ff @(posedge clk) begin
    if (re) begin
      rdData <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for the CPU load/store interface, one word access at a time.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states; otherwise every access completes in one cycle.
module dmem_responder #(
  parameter int DATA_W      = mips_pkg::DATA_W,
  parameter int DEPTH       = 32'd256,
  parameter int WAIT_CYCLES = 32'd2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              MemErr,
  output logic              Stall
);
  import mips_pkg::*;

  localparam int IDX_W = $clog2(DEPTH);

  dmem_state_t       state;
  dmem_state_t       nextState;
  logic              req;
  logic              err;
  logic              commit;
  logic              memWe;
  logic              memRe;
  logic              rdValid;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] arrayData;
  logic              unusedBits;

`ifdef DMEM_WAIT_EN
  logic [WAIT_CNT_W-1:0] cnt;
  logic [WAIT_CNT_W-1:0] nextCnt;
`endif

  assign req   = MemRead | MemWrite;
  assign err   = (Address[1:0] != 2'b00) | (MemRead & MemWrite);
  assign idx   = Address[IDX_W+1:2];
  assign Stall = req & ~MemReady;

  // Upper address bits alias away; the wait setting is irrelevant without wait states
`ifdef DMEM_WAIT_EN
  assign unusedBits = ^Address[DATA_W-1:IDX_W+2];
`else
  assign unusedBits = ^{Address[DATA_W-1:IDX_W+2], (WAIT_CYCLES != 32'd0)};
`endif

  // A reset coinciding with the committing edge must not touch the array
  assign memWe = commit & ~reset & MemWrite & ~err;
  assign memRe = commit & ~reset & MemRead & ~err;

  // Next-state logic; commit marks the edge that enters DONE
  always_comb begin
    nextState = state;
    commit    = 1'b0;
`ifdef DMEM_WAIT_EN
    nextCnt   = cnt;
`endif
    case (state)
      IDLE: begin
        if (req) begin
`ifdef DMEM_WAIT_EN
          if (WAIT_CYCLES == 32'd0) begin
            nextState = DONE;
            commit    = 1'b1;
          end else begin
            nextState = WAIT;
            nextCnt   = WAIT_CNT_W'(WAIT_CYCLES - 32'd1);
          end
`else
          nextState = DONE;
          commit    = 1'b1;
`endif
        end else begin
          nextState = IDLE;
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT: begin
        if (!req) begin
          nextState = IDLE;
        end else if (cnt == 4'd0) begin
          nextState = DONE;
          commit    = 1'b1;
        end else begin
          nextCnt = cnt - 4'd1;
        end
      end
`endif
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  // State and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      MemReady <= 1'b0;
      MemErr   <= 1'b0;
      rdValid  <= 1'b0;
    end else begin
      state    <= nextState;
      MemReady <= commit;
      if (commit) begin
        MemErr  <= err;
        rdValid <= MemRead & ~err;
      end
    end
  end

`ifdef DMEM_WAIT_EN
  // Wait-state counter
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 4'd0;
    end else begin
      cnt <= nextCnt;
    end
  end
`endif

  // Writes and errors report zero; the array output holds until the next legal load
  assign ReadData = arrayData & {DATA_W{rdValid}};

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) uArray (
    .clk    (clk),
    .we     (memWe),
    .re     (memRe),
    .idx    (idx),
    .wrData (WriteData),
    .rdData (arrayData)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder; expected latency follows DMEM_WAIT_EN.
module tb_dmem_responder;

  localparam int W = 2;
`ifdef DMEM_WAIT_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;
  logic        Stall;

  int vectors;
  int miscompares;

  dmem_responder #(
    .DATA_W      (32),
    .DEPTH       (256),
    .WAIT_CYCLES (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .Address   (Address),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .MemReady  (MemReady),
    .MemErr    (MemErr),
    .Stall     (Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One complete access: request held until MemReady, then one idle cycle
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] expData, input logic expErr);
    MemRead   = rd;
    MemWrite  = wr;
    Address   = addr;
    WriteData = wdata;
    #1;
    check({tag, "_stall_t0"}, 32'(Stall), 32'd1);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        check({tag, "_ready_early"}, 32'(MemReady), 32'd0);
        check({tag, "_stall_wait"}, 32'(Stall), 32'd1);
      end else begin
        check({tag, "_ready"}, 32'(MemReady), 32'd1);
        check({tag, "_stall_done"}, 32'(Stall), 32'd0);
        check({tag, "_err"}, 32'(MemErr), 32'(expErr));
        check({tag, "_data"}, ReadData, expData);
      end
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    @(negedge clk);
    check({tag, "_ready_pulse"}, 32'(MemReady), 32'd0);
    check({tag, "_stall_idle"}, 32'(Stall), 32'd0);
    check({tag, "_data_hold"}, ReadData, expData);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset     = 1'b1;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(MemReady), 32'd0);
    check("rst_err", 32'(MemErr), 32'd0);
    check("rst_data", ReadData, 32'h0);
    check("rst_stall", 32'(Stall), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    access("st10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    access("ld10", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    access("st13_mis", 1'b0, 1'b1, 32'h13, 32'h1, 32'h0, 1'b1);
    access("ld10_after_mis", 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Known contents at 0x20 so a dropped store is distinguishable
    access("st20", 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 32'h0, 1'b0);
    access("ld20", 1'b1, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);

    MemWrite  = 1'b1;
    Address   = 32'h20;
    WriteData = 32'h12345678;
`ifdef DMEM_WAIT_EN
    @(negedge clk);
`endif
    reset = 1'b1;
    @(negedge clk);
    check("rstwait_ready", 32'(MemReady), 32'd0);
    check("rstwait_err", 32'(MemErr), 32'd0);
    check("rstwait_data", ReadData, 32'h0);
    @(negedge clk);
    check("rstwait_ready2", 32'(MemReady), 32'd0);
    MemWrite = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    access("ld20_after_rst", 1'b1, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0);

    access("st404_alias", 1'b0, 1'b1, 32'h404, 32'hA5A5A5A5, 32'h0, 1'b0);
    access("ld004_alias", 1'b1, 1'b0, 32'h004, 32'h0, 32'hA5A5A5A5, 1'b0);

`ifdef DMEM_WAIT_EN
    MemWrite  = 1'b1;
    Address   = 32'h004;
    WriteData = 32'h0;
    @(negedge clk);
    MemWrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_no_ready", 32'(MemReady), 32'd0);
    end
    access("ld004_after_abort", 1'b1, 1'b0, 32'h004, 32'h0, 32'hA5A5A5A5, 1'b0);
`endif

    access("rdwr_both", 1'b1, 1'b1, 32'h004, 32'hFFFFFFFF, 32'h0, 1'b1);
    access("ld004_after_both", 1'b1, 1'b0, 32'h004, 32'h0, 32'hA5A5A5A5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
